jtcop_obj_dma: RTL and testbench

// Object-RAM DMA engine fed by the address decoder's obj_copy strobe (once per frame, LVBL fall).

---
 rtl/jtcop_obj_dma.sv | 148 ++++++++++++++
 tb/tb_jtcop_obj_dma.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_obj_dma.sv
// Object-RAM DMA: once per frame, grabs the 68000 bus and copies object RAM into the
// inactive half of a double-buffered object table, then flips the bank for the renderer.
module jtcop_obj_dma #(
  parameter int AW     = 10,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          obj_copy,
  output logic          busreq,
  input  logic          busack,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_dout,
  output logic [AW:0]   buf_addr,
  output logic [DW-1:0] buf_din,
  output logic          buf_we,
  output logic          buf_bank,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_COPY = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  logic [1:0]        r_state;
  logic              r_pend;
  logic              r_copy_l;
  logic              r_bank;
  logic [AW-1:0]     r_ram_addr;
  logic              r_issued_all;
  logic [RD_LAT-1:0] r_vld;
  logic [AW-1:0]     r_apipe [RD_LAT];

  logic w_req;
  logic w_in_copy;
  logic w_abort;
  logic w_issue;
  logic w_we;
  logic w_last_wr;

  assign w_req     = obj_copy & ~r_copy_l;
  assign w_in_copy = (r_state == ST_COPY);
  assign w_abort   = w_in_copy & ~busack;
  assign w_issue   = w_in_copy & busack & ~r_issued_all;
  // A read that emerges in the very cycle the grant is lost is discarded.
  assign w_we      = w_in_copy & busack & r_vld[RD_LAT-1];
  assign w_last_wr = w_we & (r_apipe[RD_LAT-1] == LAST_ADDR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_copy_l <= 1'b0;
    end else begin
      r_copy_l <= obj_copy;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_pend       <= 1'b0;
      r_bank       <= 1'b0;
      r_ram_addr   <= '0;
      r_issued_all <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req || r_pend) begin
            r_state <= ST_REQ;
          end
          r_pend <= 1'b0;
        end
        ST_REQ: begin
          if (w_req) begin
            r_pend <= 1'b1;
          end
          if (busack) begin
            r_state      <= ST_COPY;
            r_ram_addr   <= '0;
            r_issued_all <= 1'b0;
          end
        end
        ST_COPY: begin
          if (w_req) begin
            r_pend <= 1'b1;
          end
          if (w_abort) begin
            r_state      <= ST_REQ;
            r_issued_all <= 1'b0;
          end else begin
            // Address saturates on the last word; the flag stops further issues.
            if (w_issue) begin
              if (r_ram_addr == LAST_ADDR) begin
                r_issued_all <= 1'b1;
              end else begin
                r_ram_addr <= r_ram_addr + 1'b1;
              end
            end
            if (w_last_wr) begin
              r_state <= ST_DONE;
              r_bank  <= ~r_bank;
            end
          end
        end
        default: begin
          r_state <= r_pend ? ST_REQ : ST_IDLE;
          r_pend  <= w_req;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_apipe[i] <= '0;
      end
    end else begin
      if (w_abort) begin
        r_vld <= '0;
      end else begin
        r_vld[0] <= w_issue;
        for (int i = RD_LAT - 1; i > 0; i--) begin
          r_vld[i] <= r_vld[i-1];
        end
      end
      r_apipe[0] <= r_ram_addr;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_apipe[i] <= r_apipe[i-1];
      end
    end
  end

  assign ram_addr = r_ram_addr;
  assign busreq   = (r_state == ST_REQ) || (r_state == ST_COPY);
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign buf_bank = r_bank;
  assign buf_we   = w_we;
  assign buf_addr = w_we ? {~r_bank, r_apipe[RD_LAT-1]} : '0;
  assign buf_din  = w_we ? ram_dout : '0;

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Directed bench for jtcop_obj_dma with AW=4, RD_LAT=1 and a delayed-grant bus model.
module tb_jtcop_obj_dma;

  logic        clk;
  logic        rstn;
  logic        obj_copy;
  logic        busreq;
  logic        busack;
  logic [3:0]  ram_addr;
  logic [15:0] ram_dout;
  logic [4:0]  buf_addr;
  logic [15:0] buf_din;
  logic        buf_we;
  logic        buf_bank;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [2:0] ack_sr;
  logic       ack_block;

  logic [4:0]  wr_addr [$];
  logic [15:0] wr_data [$];
  int          wr_cyc  [$];
  int          done_cnt;
  logic        done_bank;
  logic        done_busreq;
  int          busreq_cyc;
  int          idle_cyc;
  int          cyc;

  jtcop_obj_dma #(.AW(4), .DW(16), .RD_LAT(1)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .obj_copy (obj_copy),
    .busreq   (busreq),
    .busack   (busack),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .buf_addr (buf_addr),
    .buf_din  (buf_din),
    .buf_we   (buf_we),
    .buf_bank (buf_bank),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Object RAM: one-cycle registered read, mem[i] = 0x100 + 3*i
  always @(posedge clk) ram_dout <= 16'h100 + {12'b0, ram_addr} * 16'd3;

  // Bus grant follows the request three cycles late
  always @(posedge clk) ack_sr <= {ack_sr[1:0], busreq};
  assign busack = ack_sr[2] & ~ack_block;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (buf_we) begin
      wr_addr.push_back(buf_addr);
      wr_data.push_back(buf_din);
      wr_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt    = done_cnt + 1;
      done_bank   = buf_bank;
      done_busreq = busreq;
    end
    if (busreq) busreq_cyc = busreq_cyc + 1;
    if (!busy) idle_cyc = idle_cyc + 1;
  end

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt   = 0;
    busreq_cyc = 0;
    idle_cyc   = 0;
  endtask

  task automatic pulse_copy();
    @(negedge clk);
    obj_copy = 1'b1;
    @(negedge clk);
    obj_copy = 1'b0;
  endtask

  task automatic wait_done(input int n, input int limit, input string name);
    int k;
    k = 0;
    while (done_cnt < n && k < limit) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (done_cnt < n) begin
      errors++;
      $display("FAIL %s timeout: done pulses=%0d required=%0d", name, done_cnt, n);
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rstn = 1'b0;
    obj_copy = 1'b0;
    ack_block = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    clear_mon();
    repeat (50) begin
      @(negedge clk);
      if (busreq || busy || done || buf_we || buf_bank || ram_addr != 0 || buf_addr != 0 || buf_din != 0)
        bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL reset_quiet: nonzero cycles=%0d required=0", bad); end
    checks++; if (busreq !== 1'b0) begin errors++; $display("FAIL reset_busreq: got=%b exp=0", busreq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got=%b exp=0", busy); end
    checks++; if (buf_bank !== 1'b0) begin errors++; $display("FAIL reset_bank: got=%b exp=0", buf_bank); end
    checks++; if (ram_addr !== 4'd0) begin errors++; $display("FAIL reset_ram_addr: got=%0d exp=0", ram_addr); end
    checks++; if (buf_addr !== 5'd0 || buf_din !== 16'd0) begin errors++; $display("FAIL reset_buf: addr=%0d din=%h exp=0/0", buf_addr, buf_din); end
    checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL reset_no_we: writes=%0d exp=0", wr_addr.size()); end
    $display("test_reset: bad cycles=%0d writes=%0d", bad, wr_addr.size());
  endtask

  task automatic test_first_copy();
    int gaps;
    clear_mon();
    pulse_copy();
    wait_done(1, 200, "first_copy");
    repeat (6) @(negedge clk);
    checks++; if (wr_addr.size() !== 16) begin errors++; $display("FAIL first_count: writes=%0d exp=16", wr_addr.size()); end
    for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== 5'(16 + i) || wr_data[i] !== 16'h100 + 16'(i * 3)) begin
        errors++;
        $display("FAIL first_write[%0d]: addr=%0d din=%h exp addr=%0d din=%h", i, wr_addr[i], wr_data[i], 16 + i, 16'h100 + 16'(i * 3));
      end
    end
    gaps = 0;
    for (int i = 1; i < wr_cyc.size(); i++) if (wr_cyc[i] != wr_cyc[i-1] + 1) gaps++;
    checks++; if (gaps !== 0) begin errors++; $display("FAIL first_contiguous: gaps=%0d exp=0", gaps); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL first_done: pulses=%0d exp=1", done_cnt); end
    checks++; if (done_bank !== 1'b1 || done_busreq !== 1'b0) begin errors++; $display("FAIL first_done_state: bank=%b busreq=%b exp 1/0", done_bank, done_busreq); end
    checks++; if (busreq_cyc !== 21) begin errors++; $display("FAIL first_busreq_len: cycles=%0d exp=21", busreq_cyc); end
    checks++; if (busy !== 1'b0 || buf_bank !== 1'b1) begin errors++; $display("FAIL first_after: busy=%b bank=%b exp 0/1", busy, buf_bank); end
    $display("test_first_copy: writes=%0d done=%0d busreq_cycles=%0d bank=%b", wr_addr.size(), done_cnt, busreq_cyc, buf_bank);
  endtask

  task automatic test_second_copy();
    clear_mon();
    pulse_copy();
    wait_done(1, 200, "second_copy");
    repeat (6) @(negedge clk);
    checks++; if (wr_addr.size() !== 16) begin errors++; $display("FAIL second_count: writes=%0d exp=16", wr_addr.size()); end
    for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== 5'(i) || wr_data[i] !== 16'h100 + 16'(i * 3)) begin
        errors++;
        $display("FAIL second_write[%0d]: addr=%0d din=%h exp addr=%0d din=%h", i, wr_addr[i], wr_data[i], i, 16'h100 + 16'(i * 3));
      end
    end
    checks++; if (buf_bank !== 1'b0) begin errors++; $display("FAIL second_bank: got=%b exp=0", buf_bank); end
    $display("test_second_copy: writes=%0d bank=%b", wr_addr.size(), buf_bank);
  endtask

  task automatic test_held_request();
    clear_mon();
    @(negedge clk);
    obj_copy = 1'b1;
    repeat (100) @(negedge clk);
    obj_copy = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (wr_addr.size() !== 16) begin errors++; $display("FAIL held_count: writes=%0d exp=16", wr_addr.size()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL held_done: pulses=%0d exp=1", done_cnt); end
    checks++; if (wr_addr.size() > 0 && wr_addr[0] !== 5'd16) begin errors++; $display("FAIL held_first_addr: got=%0d exp=16", wr_addr[0]); end
    checks++; if (buf_bank !== 1'b1) begin errors++; $display("FAIL held_bank: got=%b exp=1", buf_bank); end
    $display("test_held_request: writes=%0d done=%0d bank=%b", wr_addr.size(), done_cnt, buf_bank);
  endtask

  task automatic test_back_to_back();
    int k;
    clear_mon();
    pulse_copy();
    k = 0;
    while (wr_addr.size() < 3 && k < 200) begin @(negedge clk); k++; end
    obj_copy = 1'b1;
    @(negedge clk);
    obj_copy = 1'b0;
    @(negedge clk);
    obj_copy = 1'b1;
    @(negedge clk);
    obj_copy = 1'b0;
    wait_done(1, 200, "b2b_first");
    idle_cyc = 0;
    wait_done(2, 200, "b2b_second");
    checks++; if (idle_cyc !== 0) begin errors++; $display("FAIL b2b_no_idle: idle cycles=%0d exp=0", idle_cyc); end
    repeat (40) @(negedge clk);
    checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done: pulses=%0d exp=2", done_cnt); end
    checks++; if (wr_addr.size() !== 32) begin errors++; $display("FAIL b2b_count: writes=%0d exp=32", wr_addr.size()); end
    for (int i = 0; i < 32 && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== 5'(i) || wr_data[i] !== 16'h100 + 16'((i % 16) * 3)) begin
        errors++;
        $display("FAIL b2b_write[%0d]: addr=%0d din=%h exp addr=%0d din=%h", i, wr_addr[i], wr_data[i], i, 16'h100 + 16'((i % 16) * 3));
      end
    end
    checks++; if (buf_bank !== 1'b1) begin errors++; $display("FAIL b2b_bank: got=%b exp=1", buf_bank); end
    $display("test_back_to_back: writes=%0d done=%0d bank=%b", wr_addr.size(), done_cnt, buf_bank);
  endtask

  task automatic test_abort();
    int k;
    clear_mon();
    pulse_copy();
    k = 0;
    while (wr_addr.size() < 6 && k < 200) begin @(posedge clk); k++; end
    #1 ack_block = 1'b1;
    repeat (4) @(posedge clk);
    #1 ack_block = 1'b0;
    wait_done(1, 200, "abort");
    repeat (10) @(negedge clk);
    checks++; if (wr_addr.size() !== 22) begin errors++; $display("FAIL abort_count: writes=%0d exp=22", wr_addr.size()); end
    for (int i = 0; i < 22 && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== 5'(i < 6 ? i : i - 6) || wr_data[i] !== 16'h100 + 16'((i < 6 ? i : i - 6) * 3)) begin
        errors++;
        $display("FAIL abort_write[%0d]: addr=%0d din=%h exp addr=%0d", i, wr_addr[i], wr_data[i], (i < 6 ? i : i - 6));
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL abort_done: pulses=%0d exp=1", done_cnt); end
    checks++; if (buf_bank !== 1'b0) begin errors++; $display("FAIL abort_bank: got=%b exp=0", buf_bank); end
    $display("test_abort: writes=%0d done=%0d bank=%b", wr_addr.size(), done_cnt, buf_bank);
  endtask

  task automatic test_reset_mid_copy();
    int k;
    clear_mon();
    pulse_copy();
    wait_done(1, 200, "pre_reset_copy");
    repeat (6) @(negedge clk);
    checks++; if (buf_bank !== 1'b1) begin errors++; $display("FAIL prereset_bank: got=%b exp=1", buf_bank); end
    clear_mon();
    pulse_copy();
    k = 0;
    while (wr_addr.size() < 3 && k < 200) begin @(posedge clk); k++; end
    #1 rstn = 1'b0;
    #1;
    checks++; if (busreq !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: busreq=%b busy=%b done=%b exp 0/0/0", busreq, busy, done); end
    checks++; if (buf_bank !== 1'b0) begin errors++; $display("FAIL midreset_bank: got=%b exp=0", buf_bank); end
    checks++; if (ram_addr !== 4'd0 || buf_we !== 1'b0 || buf_addr !== 5'd0 || buf_din !== 16'd0) begin errors++; $display("FAIL midreset_data: ram_addr=%0d we=%b addr=%0d din=%h exp 0", ram_addr, buf_we, buf_addr, buf_din); end
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL postreset_busy: got=%b exp=0", busy); end
    $display("test_reset_mid_copy: writes before reset=%0d bank=%b busy=%b", wr_addr.size(), buf_bank, busy);
  endtask

  initial begin
    cyc = 0;
    ack_sr = 3'b000;
    clear_mon();
    test_reset();
    test_first_copy();
    test_second_copy();
    test_held_request();
    test_back_to_back();
    test_abort();
    test_reset_mid_copy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
